io_controller: RTL
==================

// Module: io_controller
// PURPOSE
//  Parametrised memory-mapped I/O controller for the 11xx address region (0xC00-0xFFF at ADDRESS_SIZE=12).
//  Debounces switches and push-buttons, captures button press edges, and drives LEDs and N seven-segment digits.
//  Sits beside ram_block on the CPU data port; the top-level mux selects its out when address[MSB:MSB-1]==2'b11.
// PARAMETERS
//  DATA_SIZE        16     data bus width
//  ADDRESS_SIZE     12     word address width
//  NUM_LEDS         10     LED outputs, <= DATA_SIZE
//  NUM_SWITCHES     10     slide switches, <= DATA_SIZE
//  NUM_BUTTONS      5      push-buttons (active-low pins), <= DATA_SIZE
//  NUM_HEX          6      seven-segment digits, 1..8
//  DEBOUNCE_CYCLES  50000  stable cycles required before a debounced input changes, >= 2
// PORTS
//  clk          in   1                    clock; all state on posedge
//  reset_n      in   1                    asynchronous, active-low reset
//  address      in   ADDRESS_SIZE         CPU word address
//  writeData    in   DATA_SIZE            CPU write data
//  we           in   1                    write enable
//  switches     in   NUM_SWITCHES         raw asynchronous switch pins
//  pushButtons  in   NUM_BUTTONS          raw asynchronous button pins, 0 = pressed
//  out          out  DATA_SIZE            registered read data
//  leds         out  NUM_LEDS             LED drive, 1 = lit
//  hex          out  7*NUM_HEX            segments, active-low; digit i = hex[7i+6:7i]
// BEHAVIOUR
//  Register map (all addresses all-ones-relative; unlisted upper bits zero-filled on read):
//   0xFFF LEDS     RW  [NUM_LEDS-1:0]
//   0xFFE SWITCHES RO  debounced switch levels
//   0xFFD BTN_STATE RO debounced pressed levels (1 = pressed)
//   0xFFC BTN_EDGE W1C sticky press-edge flags
//   0xFFB-i HEX[i] RW  i = 0..NUM_HEX-1; 7 bits (see CONFIGURATION)
//  Access only when address[MSB:MSB-1]==2'b11; otherwise no write, out <= 0.
//  Read latency 1: out valid the cycle after address is presented.
//  Write to an RW register: register and out both take the masked writeData next edge.
//  Writes to RO registers and unmapped IO addresses ignored; reading them returns 0 (unmapped) or value (RO).
//  Debounce per input: 2-FF synchroniser -> counter; counter clears whenever sync != stable; when it reaches
//   DEBOUNCE_CYCLES-1, stable <= sync and counter clears. Input to stable-change latency = DEBOUNCE_CYCLES+2.
//   Counter width $clog2(DEBOUNCE_CYCLES); no wrap (saturates at terminal count and resets).
//  BTN_EDGE[b] sets on the cycle BTN_STATE[b] goes 0->1; stays set until a write with writeData[b]=1.
//   Set and clear on the same cycle: set wins. Release edges are not captured.
//  Reset (reset_n=0, any time, mid-debounce included): out=0, leds=0, BTN_EDGE=0, counters=0,
//   synchronisers and stable switch levels=0, stable button pressed=0, HEX regs=0, hex=all ones (blank).
//   Buttons held through reset appear as a press edge DEBOUNCE_CYCLES+2 cycles after release of reset.
// CONFIGURATION
//  HEX_DECODE_EN defined: HEX[i] holds a 5-bit value {blank, nibble}; bit4=1 blanks the digit,
//   else nibble is decoded 0-F to segments (reset value 0x10, blank). Readback returns the 5 bits.
//  HEX_DECODE_EN undefined: HEX[i] holds raw 7-bit active-high segment pattern; hex = ~HEX[i].
// STRUCTURE
//  Shared include io_map.vh: `IO_LEDS, `IO_SWITCHES, `IO_BTN_STATE, `IO_BTN_EDGE, `IO_HEX_BASE
//   offsets and the IO region tag 2'b11; used by ram_block, this block and the top-level mux.
//  One sub-module: io_debounce #(DEBOUNCE_CYCLES) (clk, reset_n, raw, stable), one instance per
//   switch/button via generate. Hex decoder is a function inside io_controller.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Write 0x3FF to 0xFFF, read 0xFFF -> leds=0x3FF, out=0x03FF one cycle after read address.
//  2 Toggle switches[3] 1 cycle then back -> SWITCHES unchanged; hold 6+ cycles -> SWITCHES=0x008.
//  3 Press pushButtons[0] (drive 0) 10 cycles -> BTN_STATE=1, BTN_EDGE=1; release -> BTN_EDGE stays 1;
//    write 0x0001 to 0xFFC -> BTN_EDGE=0.
//  4 W1C write to 0xFFC on the same cycle a new edge on button 1 sets -> BTN_EDGE[1]=1 afterwards.
//  5 Write 0xFFFF to 0xFFE and 0xBFF -> SWITCHES unchanged, ram region untouched, out=0 for 0xBFF.
//  6 Assert reset_n=0 mid-debounce with leds=0x155, HEX[0]=0x7F -> leds=0, hex all ones, out=0 immediately.

Source files
------------

// File: rtl/io_controller_pkg.sv
// io_controller_pkg: register map offsets and HEX register format for io_controller.
// Offsets are all-ones-relative: offset = ~address[ADDRESS_SIZE-3:0].
// Optional feature macro: HEX_DECODE_EN (HEX regs hold {blank, nibble} instead of raw segments).
package io_controller_pkg;

  localparam logic [1:0] IO_TAG = 2'b11;

  localparam int IO_LEDS      = 0;
  localparam int IO_SWITCHES  = 1;
  localparam int IO_BTN_STATE = 2;
  localparam int IO_BTN_EDGE  = 3;
  localparam int IO_HEX_BASE  = 4;

`ifdef HEX_DECODE_EN
  localparam int               HEX_W   = 5;
  localparam logic [HEX_W-1:0] HEX_RST = 5'h10;
`else
  localparam int               HEX_W   = 7;
  localparam logic [HEX_W-1:0] HEX_RST = 7'h00;
`endif

endpackage

// File: rtl/io_controller_debounce.sv
// io_debounce: 2-FF synchroniser followed by a stability counter.
// The stable output follows the synchronised input only after it has
// differed from the current stable level for DEBOUNCE_CYCLES cycles.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int            CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Synchronise, count while the input disagrees with stable, commit at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/io_controller.sv
// io_controller: memory-mapped LEDs, debounced switches/buttons, button press
// flags (write-1-to-clear) and seven-segment digits in the 2'b11 address region.
// Optional feature macro: HEX_DECODE_EN.
module io_controller
  import io_controller_pkg::*;
#(
  parameter int DATA_SIZE       = 16,
  parameter int ADDRESS_SIZE    = 12,
  parameter int NUM_LEDS        = 10,
  parameter int NUM_SWITCHES    = 10,
  parameter int NUM_BUTTONS     = 5,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [DATA_SIZE-1:0]    writeData,
  input  logic                    we,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [NUM_BUTTONS-1:0]  pushButtons,
  output logic [DATA_SIZE-1:0]    out,
  output logic [NUM_LEDS-1:0]     leds,
  output logic [7*NUM_HEX-1:0]    hex
);

  localparam int                   OW       = ADDRESS_SIZE - 2;
  localparam logic [DATA_SIZE-1:0] LED_MASK = DATA_SIZE'({NUM_LEDS{1'b1}});
  localparam logic [DATA_SIZE-1:0] HEX_MASK = DATA_SIZE'({HEX_W{1'b1}});

  logic [OW-1:0]           w_off;
  logic                    w_in_io;
  logic [NUM_SWITCHES-1:0] w_sw_state;
  logic [NUM_BUTTONS-1:0]  w_btn_raw;
  logic [NUM_BUTTONS-1:0]  w_btn_state;
  logic [NUM_BUTTONS-1:0]  w_btn_rise;
  logic [NUM_BUTTONS-1:0]  w_edge_clr;
  logic [DATA_SIZE-1:0]    w_rdata;
  logic [DATA_SIZE-1:0]    w_wdata_rw;
  logic                    w_wr_rw;

  logic [NUM_LEDS-1:0]     r_leds;
  logic [NUM_BUTTONS-1:0]  r_btn_prev;
  logic [NUM_BUTTONS-1:0]  r_edge;
  logic [HEX_W-1:0]        r_hex [NUM_HEX];
  logic [DATA_SIZE-1:0]    r_out;

  assign w_off      = ~address[OW-1:0];
  assign w_in_io    = (address[ADDRESS_SIZE-1:ADDRESS_SIZE-2] == IO_TAG);
  assign w_btn_raw  = ~pushButtons;
  assign w_btn_rise = w_btn_state & ~r_btn_prev;

  genvar g;
  generate
    for (g = 0; g < NUM_SWITCHES; g++) begin : g_sw
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .reset_n(reset_n), .raw(switches[g]), .stable(w_sw_state[g])
      );
    end
    for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk), .reset_n(reset_n), .raw(w_btn_raw[g]), .stable(w_btn_state[g])
      );
    end
  endgenerate

  // Address decode: read mux, RW write detection and W1C clear mask.
  always_comb begin
    w_rdata    = '0;
    w_wr_rw    = 1'b0;
    w_wdata_rw = '0;
    w_edge_clr = '0;
    if (w_in_io) begin
      if (w_off == OW'(IO_LEDS)) begin
        w_rdata    = DATA_SIZE'(r_leds);
        w_wr_rw    = we;
        w_wdata_rw = writeData & LED_MASK;
      end else if (w_off == OW'(IO_SWITCHES)) begin
        w_rdata = DATA_SIZE'(w_sw_state);
      end else if (w_off == OW'(IO_BTN_STATE)) begin
        w_rdata = DATA_SIZE'(w_btn_state);
      end else if (w_off == OW'(IO_BTN_EDGE)) begin
        w_rdata = DATA_SIZE'(r_edge);
        if (we) w_edge_clr = writeData[NUM_BUTTONS-1:0];
      end
      for (int i = 0; i < NUM_HEX; i++) begin
        if (w_off == OW'(IO_HEX_BASE + i)) begin
          w_rdata    = DATA_SIZE'(r_hex[i]);
          w_wr_rw    = we;
          w_wdata_rw = writeData & HEX_MASK;
        end
      end
    end
  end

  // Register writes, registered read data, and sticky press flags (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_leds     <= '0;
      r_btn_prev <= '0;
      r_edge     <= '0;
      r_out      <= '0;
      for (int i = 0; i < NUM_HEX; i++) r_hex[i] <= HEX_RST;
    end else begin
      if (w_in_io && we && (w_off == OW'(IO_LEDS))) r_leds <= writeData[NUM_LEDS-1:0];
      for (int i = 0; i < NUM_HEX; i++) begin
        if (w_in_io && we && (w_off == OW'(IO_HEX_BASE + i))) r_hex[i] <= writeData[HEX_W-1:0];
      end
      r_out      <= w_wr_rw ? w_wdata_rw : w_rdata;
      r_btn_prev <= w_btn_state;
      r_edge     <= (r_edge & ~w_edge_clr) | w_btn_rise;
    end
  end

`ifdef HEX_DECODE_EN
  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F;  4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;  4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;  4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;  4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;  4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;  default: hex_seg = 7'h71;
    endcase
  endfunction

  generate
    for (g = 0; g < NUM_HEX; g++) begin : g_hex
      assign hex[7*g +: 7] = r_hex[g][4] ? 7'h7F : ~hex_seg(r_hex[g][3:0]);
    end
  endgenerate
`else
  generate
    for (g = 0; g < NUM_HEX; g++) begin : g_hex
      assign hex[7*g +: 7] = ~r_hex[g];
    end
  endgenerate
`endif

  assign out  = r_out;
  assign leds = r_leds;

endmodule
